line_pixel_writer: RTL

//  Downstream of the line generator. Consumes its per-pixel stream (signed 32-bit x/y, colour, valid)
//  and clips each pixel to the visible frame. In-range pixels are buffered in a small FIFO and

---
 rtl/line_pixel_writer_if.sv | 28 ++
 rtl/line_pixel_writer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/line_pixel_writer_if.sv
// Pixel stream input and framebuffer write port of line_pixel_writer.
// The master side is the line generator / framebuffer owner; the slave side is the writer.
interface line_pixel_writer_if #(
   parameter int COLOR_W = 4,
   parameter int ADDR_W  = 16
);
   logic               data_valid_in;
   logic signed [31:0] x_in;
   logic signed [31:0] y_in;
   logic [COLOR_W-1:0] color_in;
   logic               ready_out;
   logic               clear_in;
   logic               busy_out;
   logic [ADDR_W-1:0]  fb_addr_out;
   logic [COLOR_W-1:0] fb_data_out;
   logic               fb_we_out;
   logic [15:0]        dropped_count_out;

   modport master (
      output data_valid_in, x_in, y_in, color_in, clear_in,
      input  ready_out, busy_out, fb_addr_out, fb_data_out, fb_we_out, dropped_count_out
   );

   modport slave (
      input  data_valid_in, x_in, y_in, color_in, clear_in,
      output ready_out, busy_out, fb_addr_out, fb_data_out, fb_we_out, dropped_count_out
   );
endinterface

// File: rtl/line_pixel_writer.sv
// Clips a signed pixel stream to the visible frame, queues visible pixels in a small FIFO
// and writes them one per cycle into a framebuffer; also sweeps the whole frame on clear.
module line_pixel_writer #(
   parameter int H_RES       = 320,
   parameter int V_RES       = 180,
   parameter int COLOR_W     = 4,
   parameter int DEPTH       = 8,
   parameter int CLEAR_COLOR = 0
) (
   input logic                clk_in,
   input logic                rst_in,
   line_pixel_writer_if.slave pix
);
   localparam int                   ADDR_W    = $clog2(H_RES * V_RES);
   localparam int                   PTR_W     = $clog2(DEPTH);
   localparam int                   ENTRY_W   = 2 * ADDR_W + COLOR_W;
   localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
   localparam logic [ADDR_W-1:0]    H_RES_A   = ADDR_W'(H_RES);
   localparam logic [ADDR_W-1:0]    ADDR_ONE  = ADDR_W'(1);
   localparam logic [PTR_W:0]       PTR_ONE   = (PTR_W + 1)'(1);
   localparam logic [COLOR_W-1:0]   CLEAR_VAL = COLOR_W'(CLEAR_COLOR);

   typedef enum logic [0:0] {
      ST_DRAW  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ENTRY_W-1:0]  r_mem [DEPTH];
   logic [PTR_W:0]      r_wr_ptr;
   logic [PTR_W:0]      r_rd_ptr;
   logic [ADDR_W-1:0]   r_clr_addr;
   logic [ADDR_W-1:0]   r_fb_addr;
   logic [COLOR_W-1:0]  r_fb_data;
   logic                r_fb_we;
   logic [15:0]         r_drop_cnt;

   logic                w_empty;
   logic                w_full;
   logic                w_ready;
   logic                w_accept;
   logic                w_in_range;
   logic                w_push;
   logic                w_drop;
   logic                w_pop;
   logic                w_clear_req;
   logic                w_clear_last;
   logic [ADDR_W-1:0]   w_head_x;
   logic [ADDR_W-1:0]   w_head_y;
   logic [COLOR_W-1:0]  w_head_color;
   logic [ADDR_W-1:0]   w_pop_addr;

   // Extra pointer bit distinguishes a full FIFO from an empty one.
   assign w_empty      = (r_wr_ptr == r_rd_ptr);
   assign w_full       = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                         (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_clear_req  = (r_state == ST_DRAW) && pix.clear_in;
   assign w_ready      = (r_state == ST_DRAW) && !w_full && !pix.clear_in;
   assign w_accept     = pix.data_valid_in && w_ready;
   assign w_in_range   = (pix.x_in >= 32'sd0) && (pix.x_in < H_RES) &&
                         (pix.y_in >= 32'sd0) && (pix.y_in < V_RES);
   assign w_push       = w_accept && w_in_range;
   assign w_drop       = w_accept && !w_in_range;
   assign w_pop        = (r_state == ST_DRAW) && !w_empty && !pix.clear_in;
   assign w_clear_last = (r_clr_addr == LAST_ADDR);

   assign {w_head_x, w_head_y, w_head_color} = r_mem[r_rd_ptr[PTR_W-1:0]];
   // Coordinates are already clipped, so the product never exceeds the frame size.
   assign w_pop_addr = w_head_y * H_RES_A + w_head_x;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= ST_DRAW;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_DRAW: begin
            if (pix.clear_in) w_state_nxt = ST_CLEAR;
            else              w_state_nxt = ST_DRAW;
         end
         ST_CLEAR: begin
            if (w_clear_last) w_state_nxt = ST_DRAW;
            else              w_state_nxt = ST_CLEAR;
         end
         default: w_state_nxt = ST_DRAW;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= {pix.x_in[ADDR_W-1:0], pix.y_in[ADDR_W-1:0], pix.color_in};
      end
   end

   // Entering clear discards whatever is still queued.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (w_clear_req) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_clr_addr <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_clr_addr <= w_clear_last ? '0 : (r_clr_addr + ADDR_ONE);
      end else begin
         r_clr_addr <= '0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_fb_we   <= 1'b0;
         r_fb_addr <= '0;
         r_fb_data <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_fb_we   <= 1'b1;
         r_fb_addr <= r_clr_addr;
         r_fb_data <= CLEAR_VAL;
      end else if (w_pop) begin
         r_fb_we   <= 1'b1;
         r_fb_addr <= w_pop_addr;
         r_fb_data <= w_head_color;
      end else begin
         r_fb_we   <= 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_drop_cnt <= 16'h0000;
      end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'h0001;
      end else begin
         r_drop_cnt <= r_drop_cnt;
      end
   end

   assign pix.ready_out         = w_ready;
   assign pix.busy_out          = (r_state == ST_CLEAR) || !w_empty || r_fb_we;
   assign pix.fb_we_out         = r_fb_we;
   assign pix.fb_addr_out       = r_fb_addr;
   assign pix.fb_data_out       = r_fb_data;
   assign pix.dropped_count_out = r_drop_cnt;
endmodule
